// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared constants and encodings for the EX-stage operand forwarding block
package cpu_pkg;

    localparam int REG_ZERO = 0;

    typedef enum logic {
        ST_RUN       = 1'b0,
        ST_WAIT_LOAD = 1'b1
    } fwd_state_e;

    typedef enum logic [1:0] {
        SEL_ZERO = 2'd0,
        SEL_MEM  = 2'd1,
        SEL_WB   = 2'd2,
        SEL_BANK = 2'd3
    } opsel_e;

endpackage

// File: rtl/opfwd_tag_pipe.sv
// rtl/opfwd_tag_pipe.sv - two-stage source tag pipe mirroring the register bank read latency
module opfwd_tag_pipe #(
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              hold,
    input  logic              clear,
    input  logic [ADDR_W-1:0] addr,
    output logic [ADDR_W-1:0] tag_ex
);

    logic [ADDR_W-1:0] tag_id;

    // Flush beats hold so a squashed instruction never leaves a live tag behind.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tag_id <= '0;
            tag_ex <= '0;
        end else if (clear) begin
            tag_id <= '0;
            tag_ex <= '0;
        end else if (!hold) begin
            tag_id <= addr;
            tag_ex <= tag_id;
        end
    end

endmodule

// File: rtl/operand_forward.sv
// rtl/operand_forward.sv - EX operand forwarding and load-use stall; OPFWD_PERF_EN adds perf counters
module operand_forward
    import cpu_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 4,
    parameter int TIMEOUT_W = 8,
    parameter int PERF_W    = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic              hold,
    input  logic              clear,
    input  logic [DATA_W-1:0] rb_data_a,
    input  logic [DATA_W-1:0] rb_data_b,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr_d,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              mem_data_valid,
    input  logic              wb_we,
    input  logic [ADDR_W-1:0] wb_addr_d,
    input  logic [DATA_W-1:0] wb_data,
    output logic [DATA_W-1:0] op_a,
    output logic [DATA_W-1:0] op_b,
    output logic              stall_req,
    output logic              stall_timeout,
    output logic [PERF_W-1:0] perf_fwd_cnt,
    output logic [PERF_W-1:0] perf_stall_cnt
);

    localparam logic [ADDR_W-1:0]    ZERO_TAG = ADDR_W'(REG_ZERO);
    localparam logic [TIMEOUT_W-1:0] WD_MAX   = '1;

    logic [ADDR_W-1:0]    tag_ex_a;
    logic [ADDR_W-1:0]    tag_ex_b;
    opsel_e               sel_a;
    opsel_e               sel_b;
    logic                 haz;
    fwd_state_e           state_q;
    fwd_state_e           state_d;
    logic [TIMEOUT_W-1:0] wd_cnt;

    opfwd_tag_pipe #(.ADDR_W(ADDR_W)) u_tag_a (
        .clk    (clk),
        .reset  (reset),
        .hold   (hold),
        .clear  (clear),
        .addr   (addr_a),
        .tag_ex (tag_ex_a)
    );

    opfwd_tag_pipe #(.ADDR_W(ADDR_W)) u_tag_b (
        .clk    (clk),
        .reset  (reset),
        .hold   (hold),
        .clear  (clear),
        .addr   (addr_b),
        .tag_ex (tag_ex_b)
    );

    // A zero tag can never match a writer, so r0 destinations fall through to the bank path.
    function automatic opsel_e pick_src(input logic [ADDR_W-1:0] tag);
        if (tag == ZERO_TAG)
            return SEL_ZERO;
        else if (mem_we && mem_addr_d == tag && mem_data_valid)
            return SEL_MEM;
        else if (wb_we && wb_addr_d == tag)
            return SEL_WB;
        else
            return SEL_BANK;
    endfunction

    always_comb begin
        sel_a = pick_src(tag_ex_a);
        sel_b = pick_src(tag_ex_b);
    end

    always_comb begin
        op_a = rb_data_a;
        case (sel_a)
            SEL_ZERO: op_a = '0;
            SEL_MEM:  op_a = mem_data;
            SEL_WB:   op_a = wb_data;
            default:  op_a = rb_data_a;
        endcase
    end

    always_comb begin
        op_b = rb_data_b;
        case (sel_b)
            SEL_ZERO: op_b = '0;
            SEL_MEM:  op_b = mem_data;
            SEL_WB:   op_b = wb_data;
            default:  op_b = rb_data_b;
        endcase
    end

    assign haz = mem_we && (mem_addr_d != ZERO_TAG) && !mem_data_valid &&
                 ((mem_addr_d == tag_ex_a) || (mem_addr_d == tag_ex_b));

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state_q <= ST_RUN;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        stall_req = 1'b0;
        case (state_q)
            ST_RUN: begin
                stall_req = haz;
                if (haz)
                    state_d = ST_WAIT_LOAD;
            end
            ST_WAIT_LOAD: begin
                stall_req = !mem_data_valid;
                if (mem_data_valid)
                    state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
        if (clear)
            state_d = ST_RUN;
    end

    // Watchdog saturates instead of wrapping so the sticky flag cannot be re-armed by overflow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wd_cnt        <= '0;
            stall_timeout <= 1'b0;
        end else if (state_q == ST_WAIT_LOAD) begin
            if (wd_cnt != WD_MAX)
                wd_cnt <= wd_cnt + 1'b1;
            if (wd_cnt == WD_MAX - 1'b1)
                stall_timeout <= 1'b1;
        end else begin
            wd_cnt <= '0;
        end
    end

`ifdef OPFWD_PERF_EN
    logic [1:0]        fwd_inc;
    logic [PERF_W-1:0] fwd_cnt_q;
    logic [PERF_W-1:0] stall_cnt_q;

    always_comb begin
        fwd_inc = {1'b0, (sel_a == SEL_MEM) || (sel_a == SEL_WB)} +
                  {1'b0, (sel_b == SEL_MEM) || (sel_b == SEL_WB)};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fwd_cnt_q   <= '0;
            stall_cnt_q <= '0;
        end else if (stall_req) begin
            stall_cnt_q <= stall_cnt_q + 1'b1;
        end else begin
            fwd_cnt_q <= fwd_cnt_q + PERF_W'(fwd_inc);
        end
    end

    assign perf_fwd_cnt   = fwd_cnt_q;
    assign perf_stall_cnt = stall_cnt_q;
`else
    assign perf_fwd_cnt   = '0;
    assign perf_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_operand_forward.sv
// tb/tb_operand_forward.sv - directed and random checks of operand_forward against a queue-based model
module tb_operand_forward;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  addr_a, addr_b, mem_addr_d, wb_addr_d;
    logic        hold, clear, mem_we, mem_data_valid, wb_we;
    logic [31:0] rb_data_a, rb_data_b, mem_data, wb_data;
    logic [31:0] op_a, op_b, perf_fwd_cnt, perf_stall_cnt;
    logic        stall_req, stall_timeout;

    int          n_cmp  = 0;
    int          n_fail = 0;

    // Reference state: in-flight source indices, load-wait flag, watchdog, perf totals.
    logic [3:0]  q_a[$];
    logic [3:0]  q_b[$];
    bit          m_wait;
    int          m_wd;
    bit          m_to;
    logic [31:0] m_fwd, m_st;

    localparam int WD_LIMIT = (1 << 8) - 1;

    always #5 clk = ~clk;

    operand_forward dut (
        .clk            (clk),
        .reset          (reset),
        .addr_a         (addr_a),
        .addr_b         (addr_b),
        .hold           (hold),
        .clear          (clear),
        .rb_data_a      (rb_data_a),
        .rb_data_b      (rb_data_b),
        .mem_we         (mem_we),
        .mem_addr_d     (mem_addr_d),
        .mem_data       (mem_data),
        .mem_data_valid (mem_data_valid),
        .wb_we          (wb_we),
        .wb_addr_d      (wb_addr_d),
        .wb_data        (wb_data),
        .op_a           (op_a),
        .op_b           (op_b),
        .stall_req      (stall_req),
        .stall_timeout  (stall_timeout),
        .perf_fwd_cnt   (perf_fwd_cnt),
        .perf_stall_cnt (perf_stall_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_op(input logic [3:0] tag, input logic [31:0] rb, output bit hit);
        hit = 1'b0;
        if (tag == 4'd0) return 32'd0;
        if (mem_we && mem_addr_d == tag && mem_data_valid) begin hit = 1'b1; return mem_data; end
        if (wb_we && wb_addr_d == tag) begin hit = 1'b1; return wb_data; end
        return rb;
    endfunction

    task automatic model_reset();
        q_a = {}; q_a.push_back(4'd0); q_a.push_back(4'd0);
        q_b = {}; q_b.push_back(4'd0); q_b.push_back(4'd0);
        m_wait = 0; m_wd = 0; m_to = 0; m_fwd = 0; m_st = 0;
    endtask

    function automatic logic [31:0] exp_perf(input logic [31:0] v);
`ifdef OPFWD_PERF_EN
        return v;
`else
        return 32'd0 & v;
`endif
    endfunction

    // Called just after a falling edge with inputs already driven; returns at the next falling edge.
    task automatic step();
        logic [3:0]  ta, tb;
        logic [31:0] ea, eb;
        bit          fa, fb, haz, es;
        ta = q_a[0];
        tb = q_b[0];
        #1;
        ea  = ref_op(ta, rb_data_a, fa);
        eb  = ref_op(tb, rb_data_b, fb);
        haz = mem_we && mem_addr_d != 4'd0 && !mem_data_valid && (mem_addr_d == ta || mem_addr_d == tb);
        es  = m_wait ? !mem_data_valid : haz;
        chk("op_a", op_a, ea);
        chk("op_b", op_b, eb);
        chk("stall_req", {31'd0, stall_req}, {31'd0, es});
        chk("stall_timeout", {31'd0, stall_timeout}, {31'd0, m_to});
        chk("perf_fwd_cnt", perf_fwd_cnt, exp_perf(m_fwd));
        chk("perf_stall_cnt", perf_stall_cnt, exp_perf(m_st));
        @(posedge clk);
        if (es) m_st = m_st + 1;
        else    m_fwd = m_fwd + 32'(fa) + 32'(fb);
        if (m_wait) begin
            m_wd = (m_wd < WD_LIMIT) ? m_wd + 1 : WD_LIMIT;
            if (m_wd == WD_LIMIT) m_to = 1;
        end else begin
            m_wd = 0;
        end
        if (clear)       m_wait = 0;
        else if (m_wait) m_wait = !mem_data_valid;
        else             m_wait = haz;
        if (clear) begin
            q_a = {}; q_a.push_back(4'd0); q_a.push_back(4'd0);
            q_b = {}; q_b.push_back(4'd0); q_b.push_back(4'd0);
        end else if (!hold) begin
            q_a.push_back(addr_a); void'(q_a.pop_front());
            q_b.push_back(addr_b); void'(q_b.pop_front());
        end
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        addr_a = 0; addr_b = 0; hold = 0; clear = 0;
        mem_we = 0; mem_addr_d = 0; mem_data = 0; mem_data_valid = 1;
        wb_we = 0; wb_addr_d = 0; wb_data = 0;
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        rb_data_a = 32'h5555_0000;
        rb_data_b = 32'h6666_0000;
        model_reset();
        @(negedge clk);
        #1;
        chk("rst_op_a", op_a, 32'd0);
        chk("rst_op_b", op_b, 32'd0);
        chk("rst_stall", {31'd0, stall_req}, 32'd0);
        chk("rst_perf", perf_fwd_cnt | perf_stall_cnt, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // 1: plain bank read with two-cycle latency
        addr_a = 3; rb_data_a = 32'h11; step();
        addr_a = 0; step();
        #1 chk("t1_op_a", op_a, 32'h11);
        chk("t1_stall", {31'd0, stall_req}, 32'd0);
        step();

        // 2: MEM result beats WB result for the same register
        addr_a = 5; step();
        addr_a = 0; step();
        mem_we = 1; mem_addr_d = 5; mem_data = 32'hAA; mem_data_valid = 1;
        wb_we = 1; wb_addr_d = 5; wb_data = 32'hBB;
        #1 chk("t2_op_a", op_a, 32'hAA);
        step();
        idle_inputs();

        // 3: load-use on operand b, three stall cycles then forward
        addr_b = 7; step();
        addr_b = 0; step();
        mem_we = 1; mem_addr_d = 7; mem_data = 32'hCC; mem_data_valid = 0; hold = 1;
        #1 chk("t3_stall_first", {31'd0, stall_req}, 32'd1);
        repeat (3) step();
        mem_data_valid = 1; hold = 0;
        #1 chk("t3_op_b", op_b, 32'hCC);
        chk("t3_stall_drop", {31'd0, stall_req}, 32'd0);
        step();
        idle_inputs();

        // 4: watchdog fires on a long wait and stays set
        addr_b = 9; step();
        addr_b = 0; step();
        mem_we = 1; mem_addr_d = 9; mem_data = 32'hD9; mem_data_valid = 0; hold = 1;
        repeat (100) step();
        chk("t4_no_timeout_yet", {31'd0, stall_timeout}, 32'd0);
        repeat (200) step();
        chk("t4_timeout", {31'd0, stall_timeout}, 32'd1);
        mem_data_valid = 1; hold = 0;
        step();
        idle_inputs();
        step();
        chk("t4_timeout_sticky", {31'd0, stall_timeout}, 32'd1);

        // 5: clear beats hold; an r0 destination never forwards
        addr_a = 4; addr_b = 6; rb_data_a = 32'h44; rb_data_b = 32'h66;
        step(); step();
        hold = 1; clear = 1; step();
        hold = 0; clear = 0;
        #1 chk("t5_op_a_cleared", op_a, 32'd0);
        chk("t5_op_b_cleared", op_b, 32'd0);
        step(); step();
        mem_we = 1; mem_addr_d = 0; mem_data = 32'hDD; mem_data_valid = 1;
        #1 chk("t5_r0_no_fwd", op_a, 32'h44);
        step();
        idle_inputs();

        // 6: asynchronous reset in the middle of a load wait
        addr_a = 8; step();
        addr_a = 0; step();
        mem_we = 1; mem_addr_d = 8; mem_data_valid = 0; hold = 1;
        step(); step();
        #2 reset = 1'b1;
        #1 chk("t6_stall_async", {31'd0, stall_req}, 32'd0);
        chk("t6_timeout_clr", {31'd0, stall_timeout}, 32'd0);
        chk("t6_op_a", op_a, 32'd0);
        chk("t6_perf", perf_fwd_cnt | perf_stall_cnt, 32'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        idle_inputs();
        step();

        // Random traffic with a narrow register range to provoke matches
        for (int i = 0; i < 400; i++) begin
            addr_a         = 4'($urandom_range(0, 7));
            addr_b         = 4'($urandom_range(0, 7));
            hold           = ($urandom_range(0, 9) == 0);
            clear          = ($urandom_range(0, 19) == 0);
            rb_data_a      = $urandom;
            rb_data_b      = $urandom;
            mem_we         = $urandom_range(0, 1) == 1;
            mem_addr_d     = 4'($urandom_range(0, 7));
            mem_data       = $urandom;
            mem_data_valid = ($urandom_range(0, 9) < 7);
            wb_we          = $urandom_range(0, 1) == 1;
            wb_addr_d      = 4'($urandom_range(0, 7));
            wb_data        = $urandom;
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
